// File: rtl/capture_pkg.sv
// Shared types and default widths for the capture frame sequencer.
package capture_pkg;

  localparam int CAP_CNT_W = 16;
  localparam int CAP_LEN_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WAIT  = 3'd2,
    POST  = 3'd3,
    ABORT = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_beat_cnt.sv
// Loadable beat counter; hit is high while the next counted beat is the target one.
// Load clears the count and latches the target in one cycle; no flow control of its own.
module capture_beat_cnt
  import capture_pkg::*;
#(
  parameter int CNT_W = CAP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      target <= '0;
    end else if (load) begin
      cnt    <= '0;
      target <= load_val;
    end else if (inc) begin
      cnt <= cnt + ONE;
    end
  end

  // Extra bit keeps the compare from wrapping when target is all-ones.
  assign hit = (({1'b0, cnt} + ONE_X) == {1'b0, target});

endmodule

// File: rtl/capture_ctrl.sv
// Capture frame sequencer: combinational pass-through in PRE/WAIT/POST, flush in IDLE/ABORT;
// s_tready follows m_tready while forwarding. Optional auto-trigger under CAPTURE_CTRL_TIMEOUT_EN.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int CNT_W = CAP_CNT_W,
  parameter int LEN_W = CAP_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] pre_count,
  input  logic [CNT_W-1:0] post_count,
  input  logic             trig_in,
  input  logic             ovr_in,
  input  logic [DSIZE-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             cap_arm,
  output logic             cap_abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] frame_len
`ifdef CAPTURE_CTRL_TIMEOUT_EN
  ,
  input  logic [31:0]      tmo_cycles,
  output logic             timed_out
`endif
);

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  cap_state_t       state;
  logic             trig_prev;
  logic             trig_edge;
  logic             ovr_prev;
  logic [CNT_W-1:0] post_lat;

  logic             fwd;
  logic             beat;
  logic             abort_req;
  logic             start_ok;
  logic             go_post;
  logic             auto_trig;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_inc;
  logic             cnt_hit;
  logic             last_beat;

  assign fwd       = (state == PRE) || (state == WAIT) || (state == POST);
  assign s_tready  = fwd ? m_tready : 1'b1;
  assign m_tvalid  = fwd & s_tvalid;
  assign m_tdata   = fwd ? s_tdata : '0;
  assign beat      = fwd & s_tvalid & m_tready;
  assign m_tlast   = (state == POST) & cnt_hit & s_tvalid;
  assign last_beat = (state == POST) & cnt_hit & beat;
  assign busy      = (state != IDLE);

  assign abort_req = stop | (ovr_in & ~ovr_prev);
  assign start_ok  = (state == IDLE) & start & ~stop;
  assign go_post   = (state == WAIT) & (trig_edge | auto_trig) & ~abort_req;

  // One counter serves both phases: loaded with pre at start, with max(post,1) at trigger.
  assign cnt_load     = start_ok | go_post;
  assign cnt_load_val = start_ok ? pre_count : ((post_lat == '0) ? ONE_C : post_lat);
  assign cnt_inc      = beat & ((state == PRE) || (state == POST));

  capture_beat_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .hit      (cnt_hit)
  );

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign auto_trig = (state == WAIT) && (tmo_cycles != 32'd0) &&
                     (tmo_cnt == (tmo_cycles - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT) ? (tmo_cnt + 32'd1) : 32'd0;
      if (start_ok)
        timed_out <= 1'b0;
      else if (go_post && auto_trig)
        timed_out <= 1'b1;
    end
  end
`else
  assign auto_trig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      trig_prev <= 1'b0;
      trig_edge <= 1'b0;
      ovr_prev  <= 1'b0;
      post_lat  <= '0;
      cap_arm   <= 1'b0;
      cap_abort <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      frame_len <= '0;
    end else begin
      done      <= 1'b0;
      cap_abort <= 1'b0;
      trig_prev <= trig_in;
      ovr_prev  <= ovr_in;
      // Edges only count while waiting, so a level present at start or during PRE is ignored.
      trig_edge <= trig_in & ~trig_prev & (state == WAIT);

      if (beat && !(&frame_len))
        frame_len <= frame_len + ONE_L;

      case (state)
        IDLE: begin
          if (start_ok) begin
            post_lat  <= post_count;
            frame_len <= '0;
            aborted   <= 1'b0;
            cap_arm   <= 1'b1;
            state     <= (pre_count == '0) ? WAIT : PRE;
          end
        end
        PRE, WAIT: begin
          if (abort_req) begin
            state     <= ABORT;
            cap_abort <= 1'b1;
            cap_arm   <= 1'b0;
            aborted   <= 1'b1;
          end else if (state == PRE && cnt_inc && cnt_hit) begin
            state <= WAIT;
          end else if (go_post) begin
            state <= POST;
          end
        end
        POST: begin
          // The closing beat wins over a same-cycle abort request.
          if (last_beat) begin
            state   <= IDLE;
            done    <= 1'b1;
            cap_arm <= 1'b0;
          end else if (abort_req) begin
            state     <= ABORT;
            cap_abort <= 1'b1;
            cap_arm   <= 1'b0;
            aborted   <= 1'b1;
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus queues expected beats, a negedge monitor checks them.
module tb_capture_ctrl;

  localparam int DSIZE = 32;
  localparam int CNT_W = 16;
  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] pre_count = '0;
  logic [CNT_W-1:0] post_count = '0;
  logic             trig_in = 1'b0;
  logic             ovr_in = 1'b0;
  logic [DSIZE-1:0] s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [DSIZE-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic             cap_arm;
  logic             cap_abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] frame_len;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
  logic [31:0]      tmo_cycles = '0;
  logic             timed_out;
`endif

  capture_ctrl #(.DSIZE(DSIZE), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pre_count  (pre_count),
    .post_count (post_count),
    .trig_in    (trig_in),
    .ovr_in     (ovr_in),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .cap_arm    (cap_arm),
    .cap_abort  (cap_abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .frame_len  (frame_len)
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    ,
    .tmo_cycles (tmo_cycles),
    .timed_out  (timed_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic             l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_abort = 0;
  int   exp_done = 0;
  int   exp_abort = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DSIZE-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic start_frame(input int pre, input int post);
    pre_count  = CNT_W'(pre);
    post_count = CNT_W'(post);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Monitor: every accepted output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (done)      n_done++;
      if (cap_abort) n_abort++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_unexpected: got data %0h, required no beat", m_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(m_tdata), 64'(e.d));
          check("beat_last", 64'(m_tlast), 64'(e.l));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int j;

    // Reset state
    repeat (2) tick();
    check("rst_s_tready", 64'(s_tready), 1);
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_cap_arm", 64'(cap_arm), 0);
    check("rst_done", 64'(done), 0);
    check("rst_aborted", 64'(aborted), 0);
    check("rst_frame_len", 64'(frame_len), 0);
    reset = 1'b0;
    tick();

    // pre=4 post=3, trigger raised with beat 6; a stray start mid-frame must be ignored
    start_frame(4, 3);
    check("t1_cap_arm", 64'(cap_arm), 1);
    check("t1_busy", 64'(busy), 1);
    for (int i = 1; i <= 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DSIZE'(100 + i);
      trig_in  = (i >= 6);
      start    = (i == 3);
      if (i == 3) pre_count = '0;
      push(DSIZE'(100 + i), i == 10);
      tick();
    end
    start    = 1'b0;
    s_tvalid = 1'b0;
    exp_done++;
    check("t1_done", 64'(done), 1);
    check("t1_busy_low", 64'(busy), 0);
    check("t1_cap_arm_low", 64'(cap_arm), 0);
    check("t1_frame_len", 64'(frame_len), 10);
    tick();
    check("t1_done_pulse", 64'(done), 0);
    trig_in = 1'b0;
    tick();

    // pre=0 post=0, trigger high at start: only the second edge counts
    trig_in = 1'b1;
    start_frame(0, 0);
    for (int i = 1; i <= 8; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DSIZE'(200 + i);
      trig_in  = (i <= 3) || (i >= 6);
      push(DSIZE'(200 + i), i == 8);
      tick();
    end
    s_tvalid = 1'b0;
    exp_done++;
    check("t2_done", 64'(done), 1);
    check("t2_frame_len", 64'(frame_len), 8);

    // post=5 with m_tready toggling during POST
    trig_in = 1'b0;
    tick();
    start_frame(0, 5);
    trig_in = 1'b1;
    tick();
    tick();
    j = 0;
    for (int c = 0; c < 40 && j < 5; c++) begin
      m_tready = (c % 2 == 0);
      s_tvalid = 1'b1;
      s_tdata  = DSIZE'(300 + j);
      if (m_tready) push(DSIZE'(300 + j), j == 4);
      tick();
      if (m_tready) j++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    exp_done++;
    check("t3_beats_accepted", 64'(j), 5);
    check("t3_done", 64'(done), 1);
    check("t3_frame_len", 64'(frame_len), 5);
    tick();

    // stop in WAIT
    trig_in = 1'b0;
    start_frame(0, 2);
    for (int i = 1; i <= 2; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DSIZE'(400 + i);
      push(DSIZE'(400 + i), 1'b0);
      tick();
    end
    s_tvalid = 1'b0;
    stop     = 1'b1;
    tick();
    stop = 1'b0;
    exp_abort++;
    check("t4_cap_abort", 64'(cap_abort), 1);
    check("t4_cap_arm", 64'(cap_arm), 0);
    check("t4_aborted", 64'(aborted), 1);
    check("t4_busy_abort", 64'(busy), 1);
    tick();
    check("t4_cap_abort_pulse", 64'(cap_abort), 0);
    check("t4_busy_idle", 64'(busy), 0);
    check("t4_frame_len", 64'(frame_len), 2);
    // stop while idle changes nothing
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_idle_stop_busy", 64'(busy), 0);
    check("t4_idle_stop_aborted", 64'(aborted), 1);

    // next start clears aborted; overrun rises in PRE
    start_frame(3, 1);
    check("t5_aborted_clr", 64'(aborted), 0);
    check("t5_cap_arm", 64'(cap_arm), 1);
    s_tvalid = 1'b1;
    s_tdata  = DSIZE'(500);
    push(DSIZE'(500), 1'b0);
    tick();
    s_tvalid = 1'b0;
    ovr_in   = 1'b1;
    tick();
    exp_abort++;
    check("t5_cap_abort", 64'(cap_abort), 1);
    check("t5_aborted", 64'(aborted), 1);
    check("t5_cap_arm", 64'(cap_arm), 0);
    tick();
    s_tvalid = 1'b1;
    s_tdata  = DSIZE'(32'hdead);
    #1;
    check("t5_flush_s_tready", 64'(s_tready), 1);
    check("t5_flush_m_tvalid", 64'(m_tvalid), 0);
    check("t5_frame_len", 64'(frame_len), 1);
    tick();
    s_tvalid = 1'b0;
    ovr_in   = 1'b0;
    tick();

    // stop on the final POST beat: frame completes normally
    start_frame(0, 1);
    trig_in = 1'b1;
    tick();
    tick();
    s_tvalid = 1'b1;
    s_tdata  = DSIZE'(600);
    stop     = 1'b1;
    push(DSIZE'(600), 1'b1);
    tick();
    s_tvalid = 1'b0;
    stop     = 1'b0;
    exp_done++;
    check("t6_done", 64'(done), 1);
    check("t6_cap_abort", 64'(cap_abort), 0);
    check("t6_aborted", 64'(aborted), 0);
    check("t6_busy", 64'(busy), 0);
    trig_in = 1'b0;
    tick();

    // reset mid-frame: back to idle with no pulses
    start_frame(5, 1);
    s_tvalid = 1'b1;
    s_tdata  = DSIZE'(700);
    push(DSIZE'(700), 1'b0);
    tick();
    s_tvalid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_busy", 64'(busy), 0);
    check("t7_cap_arm", 64'(cap_arm), 0);
    check("t7_frame_len", 64'(frame_len), 0);
    tick();

`ifdef CAPTURE_CTRL_TIMEOUT_EN
    // no trigger: auto-trigger after 20 WAIT cycles
    tmo_cycles = 32'd20;
    start_frame(0, 2);
    repeat (20) tick();
    check("t8_timed_out", 64'(timed_out), 1);
    for (int i = 1; i <= 2; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DSIZE'(800 + i);
      push(DSIZE'(800 + i), i == 2);
      tick();
    end
    s_tvalid = 1'b0;
    exp_done++;
    check("t8_done", 64'(done), 1);
    tick();
`endif

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 0);
    check("done_pulses", 64'(n_done), 64'(exp_done));
    check("abort_pulses", 64'(n_abort), 64'(exp_abort));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Frame sequencer that sits between the `capture` sampler's clock-domain-crossing FIFO and the DMA stream input. It arms and aborts the sampler and forwards a bounded number of pre-trigger and post-trigger samples. It closes each frame with `m_tlast` and reports completion, abort and overrun status to the register block. All logic runs in the system clock domain; the sampled stream arrives already resynchronised.

## Interface
- `DSIZE`, 32, sample width; matches `capture` `size`
- `CNT_W`, 16, width of the pre/post sample counts
- `LEN_W`, 32, width of the frame-length counter
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a frame
- `stop`  in  1  one-cycle software abort request
- `pre_count`  in  CNT_W  samples to forward before trigger gating opens
- `post_count`  in  CNT_W  samples to forward after the trigger; 0 is treated as 1
- `trig_in`  in  1  sampler `triggered` level, already in `clk` domain
- `ovr_in`  in  1  sampler `overrun` level, already in `clk` domain
- `s_tdata` / `s_tvalid` / `s_tready`  in/in/out  DSIZE/1/1  stream from the CDC FIFO
- `m_tdata` / `m_tvalid` / `m_tready` / `m_tlast`  out/out/in/out  DSIZE/1/1/1  stream to DMA
- `cap_arm`  out  1  level to sampler `arm`
- `cap_abort`  out  1  one-cycle pulse to sampler `abort`
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when a frame completes
- `aborted`  out  1  sticky; cleared by the next accepted `start`
- `frame_len`  out  LEN_W  beats forwarded in the last or current frame

## Operation
- States: IDLE, PRE, WAIT, POST, ABORT.
- A beat is `s_tvalid & s_tready`.
- In PRE, WAIT and POST, `m_tdata = s_tdata`, `m_tvalid = s_tvalid`, `s_tready = m_tready`. The pass-through is combinational.
- In IDLE and ABORT, `s_tready = 1` and `m_tvalid = 0`, so the FIFO is flushed and its data discarded.
- IDLE → PRE on `start` with `stop = 0`.
  - Latch `pre_count` and `post_count`, clear `frame_len` and `aborted`, assert `cap_arm`.
  - If the latched `pre_count == 0`, go to WAIT directly.
- PRE: count beats. When the beat count reaches the latched pre value, go to WAIT. `trig_in` is ignored in PRE.
- WAIT: forward beats without limit. A registered rising edge of `trig_in` moves to POST.
  - The edge detector is cleared on entering PRE, so a `trig_in` already high at `start` does not count.
- POST: count beats. The beat at count == `max(post,1)` carries `m_tlast = 1`. On that beat, go to IDLE, pulse `done`, drop `cap_arm`.
- `frame_len` increments on every forwarded beat and saturates at all-ones.
- `stop`, or a rising edge of `ovr_in`, in PRE, WAIT or POST:
  - Go to ABORT and pulse `cap_abort` for one cycle.
  - Drop `cap_arm`, set `aborted`.
  - No `m_tlast` is emitted; DMA recovery is software's job.
  - ABORT lasts exactly one cycle, then goes to IDLE.
- Boundary and simultaneous events:
  - `start` while busy: ignored.
  - `stop` in IDLE: ignored.
  - `stop` on the same cycle as the final POST beat: the beat completes with `m_tlast`, `done` pulses, and `stop` is ignored.
  - Trigger edge on the same cycle as the last PRE beat: ignored.
- Counter compare is unsigned at CNT_W; the maximum `pre_count` forwards 2^CNT_W−1 beats.

## Timing
- Reset values: all outputs 0, `s_tready` 1, state IDLE.
- `cap_arm` rises the cycle after `start` is sampled.
- The first forwardable beat can transfer the cycle after `start`.
- `trig_in` edge to POST entry: 2 cycles (edge register plus state register).
- `done` is high on the cycle after the `m_tlast` beat.
- `busy` is low on that same cycle.
- Reset mid-frame: immediate return to IDLE with no `done` or `cap_abort` pulse.

## Configuration
- `CAPTURE_CTRL_TIMEOUT_EN` defined:
  - Adds input `tmo_cycles` [31:0] and output `timed_out` (sticky, cleared on `start`).
  - A cycle counter runs in WAIT.
  - When it reaches a nonzero `tmo_cycles`, the block behaves as if a trigger edge occurred (auto-trigger) and sets `timed_out`.
  - `tmo_cycles = 0` disables the timeout.
- `CAPTURE_CTRL_TIMEOUT_EN` undefined: both ports are absent and WAIT waits indefinitely.

## Structure
- `capture_pkg` holds:
  - the state enum `cap_state_t` (3-bit, IDLE = 0);
  - the default widths `CAP_CNT_W` and `CAP_LEN_W`.
- The block has one sub-module, `capture_beat_cnt`: a loadable CNT_W compare counter with a `hit` output. It is instantiated once and shared by PRE and POST (reloaded on state entry).

## Test plan
- pre = 4, post = 3, trigger after beat 6, `m_tready` = 1: exactly 10 beats forwarded, `m_tlast` on the 10th, `done` one cycle later, `frame_len` = 10.
- pre = 0, post = 0, `trig_in` already high at `start`, then low, then high: no POST until the second edge; 1 post beat carries `m_tlast`.
- `m_tready` toggling 50% during POST with post = 5: no beat dropped or duplicated; `m_tlast` on the 5th accepted post beat.
- `stop` in WAIT: `cap_abort` pulses once, `cap_arm` falls, `aborted` = 1, no `m_tlast`; a following `start` clears `aborted`.
- `ovr_in` rises during PRE: same response as `stop`; FIFO flushed in IDLE (`s_tready` = 1, `m_tvalid` = 0).
- With `CAPTURE_CTRL_TIMEOUT_EN` and `tmo_cycles` = 20, no trigger: POST entered after 20 WAIT cycles, `timed_out` = 1, and the frame completes normally.
